// File: rtl/div_share_arbiter.sv
// Shares one serial divider between NUM_REQ requesters: round-robin issue, one op in flight,
// owner-routed registered response, and flush that aborts the divider and drops the op.
module div_share_arbiter #(
  parameter int NUM_REQ       = 2,
  parameter int XLEN          = 64,
  parameter int TRANS_ID_BITS = 3
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             flush_i,
  input  logic [NUM_REQ-1:0]               req_valid_i,
  output logic [NUM_REQ-1:0]               req_ready_o,
  input  logic [2*NUM_REQ-1:0]             req_opcode_i,
  input  logic [XLEN*NUM_REQ-1:0]          req_op_a_i,
  input  logic [XLEN*NUM_REQ-1:0]          req_op_b_i,
  input  logic [TRANS_ID_BITS*NUM_REQ-1:0] req_id_i,
  output logic [NUM_REQ-1:0]               rsp_valid_o,
  input  logic [NUM_REQ-1:0]               rsp_ready_i,
  output logic [XLEN-1:0]                  rsp_result_o,
  output logic [TRANS_ID_BITS-1:0]         rsp_id_o,
  output logic                             div_in_vld_o,
  input  logic                             div_in_rdy_i,
  output logic [1:0]                       div_opcode_o,
  output logic [XLEN-1:0]                  div_op_a_o,
  output logic [XLEN-1:0]                  div_op_b_o,
  output logic [TRANS_ID_BITS-1:0]         div_id_o,
  output logic                             div_flush_o,
  input  logic                             div_out_vld_i,
  output logic                             div_out_rdy_o,
  input  logic [TRANS_ID_BITS-1:0]         div_id_i,
  input  logic [XLEN-1:0]                  div_res_i
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W:0] NUM_REQ_W = (PTR_W+1)'(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_e;

  state_e                   state_reg;
  logic [PTR_W-1:0]         rr_ptr_reg;
  logic [PTR_W-1:0]         owner_reg;
  logic [NUM_REQ-1:0]       rsp_valid_reg;
  logic [XLEN-1:0]          result_reg;
  logic [TRANS_ID_BITS-1:0] id_reg;
  logic [TRANS_ID_BITS-1:0] issued_id_reg;

  logic [1:0]               opcode_arr [NUM_REQ];
  logic [XLEN-1:0]          op_a_arr   [NUM_REQ];
  logic [XLEN-1:0]          op_b_arr   [NUM_REQ];
  logic [TRANS_ID_BITS-1:0] id_arr     [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign opcode_arr[gi] = req_opcode_i[2*gi +: 2];
    assign op_a_arr[gi]   = req_op_a_i[XLEN*gi +: XLEN];
    assign op_b_arr[gi]   = req_op_b_i[XLEN*gi +: XLEN];
    assign id_arr[gi]     = req_id_i[TRANS_ID_BITS*gi +: TRANS_ID_BITS];
  end

  // Rotating priority search starting at rr_ptr; defaults to requester 0 when nobody is valid.
  logic [PTR_W-1:0] winner;
  logic [PTR_W:0]   scan_idx;
  logic             found;
  always_comb begin
    winner   = '0;
    found    = 1'b0;
    scan_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = {1'b0, rr_ptr_reg} + (PTR_W+1)'(k);
      if (scan_idx >= NUM_REQ_W) scan_idx = scan_idx - NUM_REQ_W;
      if (!found && req_valid_i[scan_idx[PTR_W-1:0]]) begin
        found  = 1'b1;
        winner = scan_idx[PTR_W-1:0];
      end
    end
  end

  logic [PTR_W:0]   ptr_inc;
  logic [PTR_W-1:0] ptr_next;
  assign ptr_inc  = {1'b0, winner} + (PTR_W+1)'(1);
  assign ptr_next = (ptr_inc == NUM_REQ_W) ? '0 : ptr_inc[PTR_W-1:0];

  logic issue;
  assign div_in_vld_o  = (state_reg == IDLE) && (|req_valid_i) && !flush_i;
  assign issue         = div_in_vld_o && div_in_rdy_i;
  assign req_ready_o   = issue ? (ONE_HOT0 << winner) : '0;
  assign div_opcode_o  = opcode_arr[winner];
  assign div_op_a_o    = op_a_arr[winner];
  assign div_op_b_o    = op_b_arr[winner];
  assign div_id_o      = id_arr[winner];
  assign div_flush_o   = flush_i;
  assign div_out_rdy_o = (state_reg == BUSY) && !flush_i;
  assign rsp_valid_o   = rsp_valid_reg;
  assign rsp_result_o  = result_reg;
  assign rsp_id_o      = id_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg     <= IDLE;
      rr_ptr_reg    <= '0;
      owner_reg     <= '0;
      rsp_valid_reg <= '0;
      result_reg    <= '0;
      id_reg        <= '0;
      issued_id_reg <= '0;
    end else if (flush_i) begin
      // Arbitration fairness survives a flush: only the in-flight op is discarded.
      state_reg     <= IDLE;
      rsp_valid_reg <= '0;
      result_reg    <= '0;
      id_reg        <= '0;
    end else begin
      case (state_reg)
        IDLE: if (issue) begin
          owner_reg     <= winner;
          rr_ptr_reg    <= ptr_next;
          issued_id_reg <= div_id_o;
          state_reg     <= BUSY;
        end
        BUSY: if (div_out_vld_i) begin
          result_reg    <= div_res_i;
          id_reg        <= div_id_i;
          rsp_valid_reg <= ONE_HOT0 << owner_reg;
          state_reg     <= RESP;
        end
        RESP: if (rsp_ready_i[owner_reg]) begin
          rsp_valid_reg <= '0;
          state_reg     <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  a_id_match: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_reg == BUSY && div_out_vld_i && div_out_rdy_o) |-> (div_id_i == issued_id_reg));
  a_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(req_ready_o) && $onehot0(rsp_valid_o));
  a_no_idle_result: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_reg == IDLE) |-> !div_out_vld_i);

endmodule

// File: tb/tb_div_share_arbiter.sv
// Randomised and directed bench for div_share_arbiter with three requesters, a behavioural
// divider and a transaction-level reference model checked every cycle.
module tb_div_share_arbiter;
  localparam int N  = 3;
  localparam int XL = 64;
  localparam int IW = 3;

  logic            clk = 1'b0;
  logic            rst_ni = 1'b0;
  logic            flush_i;
  logic [N-1:0]    req_valid_i, req_ready_o, rsp_valid_o, rsp_ready_i;
  logic [2*N-1:0]  req_opcode_i;
  logic [XL*N-1:0] req_op_a_i, req_op_b_i;
  logic [IW*N-1:0] req_id_i;
  logic [XL-1:0]   rsp_result_o, div_op_a_o, div_op_b_o, div_res_i;
  logic [IW-1:0]   rsp_id_o, div_id_o, div_id_i;
  logic            div_in_vld_o, div_in_rdy_i, div_flush_o, div_out_vld_i, div_out_rdy_o;
  logic [1:0]      div_opcode_o;

  div_share_arbiter #(.NUM_REQ(N), .XLEN(XL), .TRANS_ID_BITS(IW)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_opcode_i(req_opcode_i),
    .req_op_a_i(req_op_a_i), .req_op_b_i(req_op_b_i), .req_id_i(req_id_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_result_o(rsp_result_o),
    .rsp_id_o(rsp_id_o), .div_in_vld_o(div_in_vld_o), .div_in_rdy_i(div_in_rdy_i),
    .div_opcode_o(div_opcode_o), .div_op_a_o(div_op_a_o), .div_op_b_o(div_op_b_o),
    .div_id_o(div_id_o), .div_flush_o(div_flush_o), .div_out_vld_i(div_out_vld_i),
    .div_out_rdy_o(div_out_rdy_o), .div_id_i(div_id_i), .div_res_i(div_res_i)
  );

  initial forever #5 clk = ~clk;

  // Requester environment
  bit          e_vld [N];
  bit          e_refill [N];
  logic [1:0]  e_opc [N];
  logic [63:0] e_a [N];
  logic [63:0] e_b [N];
  logic [2:0]  e_id [N];
  // Divider environment
  bit          d_busy;
  int          d_cnt, d_lat;
  logic [63:0] d_res;
  logic [2:0]  d_id;
  bit          rnd_mode;
  logic        flush_cmd;
  logic [N-1:0] rspr_cmd;
  // Reference model: one op at most, either inside the divider or waiting for its owner
  bit          m_infl, m_have;
  int          m_ptr, m_owner;
  logic [63:0] m_res;
  logic [2:0]  m_id;

  typedef struct { int who; logic [63:0] res; logic [2:0] id; } rsp_t;
  int   grant_q[$];
  rsp_t rsp_q[$];
  int   n_checks = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [63:0] calc(input logic [1:0] opc, input logic [63:0] a, input logic [63:0] b);
    logic signed [63:0] sa, sb;
    sa = a;
    sb = b;
    if (b == 64'd0) return opc[1] ? a : '1;
    if (opc[0]) begin
      if (a == 64'h8000_0000_0000_0000 && b == '1) return opc[1] ? 64'd0 : a;
      return opc[1] ? 64'(sa % sb) : 64'(sa / sb);
    end
    return opc[1] ? (a % b) : (a / b);
  endfunction

  task automatic set_req(input int i, input logic [1:0] opc, input logic [63:0] a,
                         input logic [63:0] b, input logic [2:0] id);
    e_vld[i] = 1'b1; e_opc[i] = opc; e_a[i] = a; e_b[i] = b; e_id[i] = id;
  endtask

  task automatic new_rand_req(input int i);
    logic [63:0] a, b;
    case ($urandom % 4)
      0: a = 64'($urandom % 1000);
      1: a = {$urandom, $urandom};
      2: a = 64'h8000_0000_0000_0000;
      default: a = -64'($urandom % 5000);
    endcase
    case ($urandom % 5)
      0: b = 64'd0;
      1: b = '1;
      2: b = {$urandom, $urandom};
      default: b = 64'($urandom_range(1, 50));
    endcase
    set_req(i, 2'($urandom), a, b, 3'($urandom));
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    flush_i = 1'b0; req_valid_i = '0; req_opcode_i = '0; req_op_a_i = '0; req_op_b_i = '0;
    req_id_i = '0; rsp_ready_i = '0; div_in_rdy_i = 1'b0; div_out_vld_i = 1'b0;
    div_res_i = '0; div_id_i = '0;
    for (int i = 0; i < N; i++) begin e_vld[i] = 0; e_refill[i] = 0; end
    d_busy = 0; d_cnt = 0; d_lat = 3; rnd_mode = 0; flush_cmd = 1'b0; rspr_cmd = '1;
    m_infl = 0; m_have = 0; m_ptr = 0; m_owner = 0; m_res = '0; m_id = '0;
    grant_q.delete(); rsp_q.delete();
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    #1;
  endtask

  // One clock cycle: drive at the falling edge, then compare, log and advance model/env.
  task automatic step();
    int  win;
    bit  idle, exp_in_vld, hs;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      req_valid_i[i] = e_vld[i];
      req_opcode_i[2*i +: 2] = e_opc[i];
      req_op_a_i[XL*i +: XL] = e_a[i];
      req_op_b_i[XL*i +: XL] = e_b[i];
      req_id_i[IW*i +: IW] = e_id[i];
    end
    flush_i = flush_cmd;
    rsp_ready_i = rspr_cmd;
    div_in_rdy_i = !d_busy && (!rnd_mode || ($urandom % 4 != 0));
    div_out_vld_i = d_busy && (d_cnt == 0);
    div_res_i = d_res;
    div_id_i = d_id;
    #1;
    idle = !m_infl && !m_have;
    win = -1;
    for (int k = 0; k < N; k++) if (win < 0 && e_vld[(m_ptr + k) % N]) win = (m_ptr + k) % N;
    exp_in_vld = idle && (win >= 0) && !flush_cmd;
    hs = exp_in_vld && div_in_rdy_i;
    chk("req_ready", 64'(req_ready_o), hs ? (64'(1) << win) : 64'd0);
    chk("div_in_vld", 64'(div_in_vld_o), 64'(exp_in_vld));
    chk("div_flush", 64'(div_flush_o), 64'(flush_cmd));
    chk("div_out_rdy", 64'(div_out_rdy_o), 64'(m_infl && !flush_cmd));
    chk("rsp_valid", 64'(rsp_valid_o), m_have ? (64'(1) << m_owner) : 64'd0);
    if (exp_in_vld) begin
      chk("div_opcode", 64'(div_opcode_o), 64'(e_opc[win]));
      chk("div_op_a", div_op_a_o, e_a[win]);
      chk("div_op_b", div_op_b_o, e_b[win]);
      chk("div_id", 64'(div_id_o), 64'(e_id[win]));
    end
    if (m_have) begin
      chk("rsp_result", rsp_result_o, m_res);
      chk("rsp_id", 64'(rsp_id_o), 64'(m_id));
    end
    for (int i = 0; i < N; i++) begin
      if (req_ready_o[i]) grant_q.push_back(i);
      if (rsp_valid_o[i] && rspr_cmd[i] && !flush_cmd) rsp_q.push_back('{i, rsp_result_o, rsp_id_o});
    end
    if (flush_cmd) begin
      m_infl = 0; m_have = 0;
    end else if (hs) begin
      m_infl = 1; m_owner = win; m_ptr = (win + 1) % N;
      m_res = calc(e_opc[win], e_a[win], e_b[win]); m_id = e_id[win];
    end else if (m_infl && div_out_vld_i) begin
      m_infl = 0; m_have = 1;
    end else if (m_have && rspr_cmd[m_owner]) begin
      m_have = 0;
    end
    for (int i = 0; i < N; i++) begin
      if (req_ready_o[i]) begin
        if (e_refill[i]) new_rand_req(i); else e_vld[i] = 0;
      end
      if (rnd_mode && !e_vld[i] && ($urandom % 4 == 0)) new_rand_req(i);
    end
    if (flush_cmd) d_busy = 0;
    else if (div_out_vld_i && div_out_rdy_o) d_busy = 0;
    else if (d_busy && d_cnt > 0) d_cnt--;
    else if (div_in_vld_o && div_in_rdy_i) begin
      d_busy = 1;
      d_cnt = rnd_mode ? int'($urandom_range(0, 5)) : d_lat;
      d_res = calc(div_opcode_o, div_op_a_o, div_op_b_o);
      d_id = div_id_o;
    end
  endtask

  task automatic run_until_rsp(input string nm, input int n, input int bound);
    int t = 0;
    while (rsp_q.size() < n && t < bound) begin step(); t++; end
    chk(nm, 64'(rsp_q.size()), 64'(n));
  endtask

  task automatic run_until_grants(input string nm, input int n, input int bound);
    int t = 0;
    while (grant_q.size() < n && t < bound) begin step(); t++; end
    chk(nm, 64'(grant_q.size() >= n), 64'd1);
  endtask

  initial begin
    int t;
    do_reset();
    chk("reset_rsp_valid", 64'(rsp_valid_o), 64'd0);
    chk("reset_req_ready", 64'(req_ready_o), 64'd0);
    chk("reset_div_in_vld", 64'(div_in_vld_o), 64'd0);
    chk("reset_div_out_rdy", 64'(div_out_rdy_o), 64'd0);
    chk("reset_div_flush", 64'(div_flush_o), 64'd0);
    chk("reset_result", rsp_result_o, 64'd0);
    chk("reset_id", 64'(rsp_id_o), 64'd0);

    // Single requester: udiv 100/7 id 5
    set_req(0, 2'b00, 64'd100, 64'd7, 3'd5);
    run_until_rsp("t1_done", 1, 30);
    if (rsp_q.size() >= 1) begin
      chk("t1_owner", 64'(rsp_q[0].who), 64'd0);
      chk("t1_result", rsp_q[0].res, 64'd14);
      chk("t1_id", 64'(rsp_q[0].id), 64'd5);
    end

    // Both valid from reset: urem 100/7 then div -20/3, twice, order 0,1 each time
    do_reset();
    for (int r = 0; r < 2; r++) begin
      grant_q.delete(); rsp_q.delete();
      set_req(0, 2'b10, 64'd100, 64'd7, 3'd1);
      set_req(1, 2'b01, -64'd20, 64'd3, 3'd2);
      run_until_rsp("t2_done", 2, 60);
      if (rsp_q.size() >= 2 && grant_q.size() >= 2) begin
        chk("t2_grant0", 64'(grant_q[0]), 64'd0);
        chk("t2_grant1", 64'(grant_q[1]), 64'd1);
        chk("t2_urem", rsp_q[0].res, 64'd2);
        chk("t2_div", rsp_q[1].res, 64'hFFFF_FFFF_FFFF_FFFA);
      end
    end

    // Backpressure in RESP while requester 1 waits
    do_reset();
    d_lat = 2; rspr_cmd = '0;
    set_req(0, 2'b00, 64'd1000, 64'd10, 3'd3);
    step();
    set_req(1, 2'b00, 64'd9, 64'd3, 3'd4);
    t = 0;
    while (rsp_valid_o[0] !== 1'b1 && t < 20) begin step(); t++; end
    chk("t3_reached_resp", 64'(rsp_valid_o), 64'd1);
    repeat (5) begin
      step();
      chk("t3_hold_valid", 64'(rsp_valid_o), 64'd1);
      chk("t3_hold_result", rsp_result_o, 64'd100);
      chk("t3_hold_id", 64'(rsp_id_o), 64'd3);
      chk("t3_no_grant", 64'(grant_q.size()), 64'd1);
    end
    rspr_cmd = '1;
    step();
    step();
    chk("t3_next_grant", 64'(req_ready_o), 64'd2);
    run_until_rsp("t3_done", 2, 30);

    // Flush three cycles after issue
    do_reset();
    d_lat = 8;
    set_req(0, 2'b01, -64'd50, 64'd7, 3'd4);
    run_until_grants("t4_issue", 1, 10);
    step(); step();
    flush_cmd = 1'b1; step();
    chk("t4_div_flush", 64'(div_flush_o), 64'd1);
    flush_cmd = 1'b0;
    repeat (15) step();
    chk("t4_dropped", 64'(rsp_q.size()), 64'd0);
    set_req(0, 2'b00, 64'd5, 64'd5, 3'd1);
    set_req(1, 2'b00, 64'd81, 64'd9, 3'd6);
    run_until_rsp("t4_after", 2, 60);
    if (grant_q.size() >= 2 && rsp_q.size() >= 1) begin
      chk("t4_ptr_kept", 64'(grant_q[1]), 64'd1);
      chk("t4_result", rsp_q[0].res, 64'd9);
    end

    // Flush in RESP, then flush in the issue cycle
    do_reset();
    rspr_cmd = '0;
    set_req(1, 2'b00, 64'd30, 64'd4, 3'd7);
    t = 0;
    while (rsp_valid_o[1] !== 1'b1 && t < 20) begin step(); t++; end
    chk("t5_reached_resp", 64'(rsp_valid_o), 64'd2);
    flush_cmd = 1'b1; step();
    flush_cmd = 1'b0; rspr_cmd = '1;
    repeat (3) step();
    chk("t5_resp_dropped", 64'(rsp_q.size()), 64'd0);
    chk("t5_rsp_valid_low", 64'(rsp_valid_o), 64'd0);
    grant_q.delete();
    set_req(0, 2'b00, 64'd8, 64'd2, 3'd0);
    set_req(1, 2'b00, 64'd8, 64'd4, 3'd1);
    set_req(2, 2'b00, 64'd8, 64'd8, 3'd2);
    flush_cmd = 1'b1; step();
    chk("t5_issue_flush_ready", 64'(req_ready_o), 64'd0);
    chk("t5_issue_flush_vld", 64'(div_in_vld_o), 64'd0);
    flush_cmd = 1'b0;
    run_until_rsp("t5_drain", 3, 80);
    if (grant_q.size() >= 1) chk("t5_ptr_kept", 64'(grant_q[0]), 64'd2);

    // Continuous requesters: wrap-around and skipping an idle requester
    do_reset();
    for (int i = 0; i < N; i++) begin e_refill[i] = 1; new_rand_req(i); end
    run_until_grants("t6_grants", 4, 100);
    if (grant_q.size() >= 4)
      for (int g = 0; g < 4; g++) chk("t6_rr_all", 64'(grant_q[g]), 64'(g % 3));
    do_reset();
    e_refill[0] = 1; e_refill[2] = 1; new_rand_req(0); new_rand_req(2);
    run_until_grants("t6b_grants", 3, 100);
    if (grant_q.size() >= 3) begin
      chk("t6b_g0", 64'(grant_q[0]), 64'd0);
      chk("t6b_g1", 64'(grant_q[1]), 64'd2);
      chk("t6b_g2", 64'(grant_q[2]), 64'd0);
    end

    // Random traffic with random backpressure, divider stalls and flushes
    do_reset();
    rnd_mode = 1;
    repeat (3000) begin
      flush_cmd = ($urandom % 40 == 0);
      rspr_cmd = N'($urandom);
      step();
    end
    chk("rand_progress", 64'(rsp_q.size() > 50), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/div_share_arbiter.md
Name: div_share_arbiter

Overview:
Shares one serial divider instance (two-bit opcode, in/out valid-ready, id tag, flush) between NUM_REQ requesters, e.g. integer pipe and a second issue port or a second hart.
- Round-robin grant, one outstanding division at a time.
- Owner tracking, so the result is routed back to the requester that issued it.
- Registered response stage, so requester backpressure is decoupled from the divider.
- Flush handling: abort the divider and drop the in-flight op.

Parameters:
NUM_REQ, 2, number of requesters (>=2)
XLEN, 64, operand/result width
TRANS_ID_BITS, 3, transaction id width

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
flush_i  in  1  pipeline flush, aborts everything in flight
req_valid_i  in  NUM_REQ  per-requester request valid
req_ready_o  out  NUM_REQ  per-requester accept, one-hot or zero
req_opcode_i  in  2*NUM_REQ  per-requester opcode {rem,signed}: 00 udiv, 10 urem, 01 div, 11 rem
req_op_a_i  in  XLEN*NUM_REQ  dividend per requester
req_op_b_i  in  XLEN*NUM_REQ  divisor per requester
req_id_i  in  TRANS_ID_BITS*NUM_REQ  trans id per requester
rsp_valid_o  out  NUM_REQ  result valid, one-hot to owner
rsp_ready_i  in  NUM_REQ  per-requester result accept
rsp_result_o  out  XLEN  latched quotient/remainder
rsp_id_o  out  TRANS_ID_BITS  latched trans id
div_in_vld_o  out  1  divider request valid
div_in_rdy_i  in  1  divider ready
div_opcode_o  out  2  muxed opcode
div_op_a_o  out  XLEN  muxed dividend
div_op_b_o  out  XLEN  muxed divisor
div_id_o  out  TRANS_ID_BITS  muxed id
div_flush_o  out  1  divider flush
div_out_vld_i  in  1  divider result valid
div_out_rdy_o  out  1  accept divider result
div_id_i  in  TRANS_ID_BITS  divider result id
div_res_i  in  XLEN  divider result

Behaviour:
- Reset: state IDLE, rr_ptr=0, owner=0, result/id registers 0. All outputs 0 except the combinational muxes, which show requester 0 data.
- Clock and reset: clk_i, rst_ni asynchronous active-low.
- Arbitration: winner = first i with req_valid_i[i], searching from rr_ptr upward modulo NUM_REQ.
- IDLE:
  - div_in_vld_o = any valid & ~flush_i; div_* data muxed from the winner.
  - On div_in_vld_o & div_in_rdy_i: req_ready_o[winner]=1 (same cycle, combinational), owner<=winner, rr_ptr<=(winner+1) mod NUM_REQ, go BUSY.
  - Otherwise req_ready_o=0. Requesters hold valid and data stable until ready.
- BUSY:
  - div_in_vld_o=0; div_out_rdy_o = ~flush_i.
  - On div_out_vld_i & div_out_rdy_o: capture div_res_i and div_id_i, go RESP.
- RESP:
  - rsp_valid_o[owner]=1 from a register (result is seen 1 cycle after divider handshake); div_out_rdy_o=0.
  - On rsp_ready_i[owner]: go IDLE. A new arbitration happens the next cycle, so there is no back-to-back issue in the same cycle.
  - rsp_result_o and rsp_id_o stay stable while rsp_valid_o is held.
- Flush (any state):
  - div_flush_o=flush_i (combinational).
  - State<=IDLE; response register content dropped.
  - rr_ptr unchanged by a flush; owner unchanged.
  - Flush in the issue cycle means no issue and no req_ready_o.
  - Flush coincident with div_out_vld_i means the result is not captured.
- Throughput: at most one division outstanding. Minimum occupancy per op = 1 issue cycle + divider latency + 1 RESP cycle.
- Assertions:
  - div_id_i equals the issued id on capture.
  - req_ready_o and rsp_valid_o are each $onehot0.
  - div_out_vld_i never arrives in IDLE.

Test Plan:
- Single requester 0: udiv 100/7, id 5 → req_ready_o[0] in the issue cycle. rsp_valid_o=01, rsp_result_o=14, rsp_id_o=5, one cycle after div_out_vld_i. Back to IDLE.
- Both requesters valid from reset: req0 urem 100/7, req1 div -20/3 → req0 granted first (rsp 2), then req1 (rsp -6). A second simultaneous pair grants in order 1 then 0 only if rr_ptr=1; check rr_ptr=0 after req1 completes, so order is 0, 1 again.
- Backpressure: hold rsp_ready_i[0]=0 for 5 cycles in RESP → rsp_valid_o and data stable, div_out_rdy_o=0, no new grant. Release → IDLE next cycle.
- Flush in BUSY: flush_i pulse 3 cycles after issue → div_flush_o=1 that cycle, state IDLE, no rsp_valid_o ever for that op. A subsequent request completes normally.
- Flush in RESP, and flush in the issue cycle: response dropped, or no req_ready_o and no issue, respectively. rr_ptr unchanged in both cases.
- NUM_REQ=3, all valid continuously → grants 0, 1, 2, 0 (wrap-around). With requester 1 idle → grants 0, 2, 0.
